// File: rtl/reel_sprite_reader.sv
// One slot-machine reel: spin/stop state machine and scroll offset, sprite ROM
// addressing for a 128x128 window, and a 3-stage pixel pipeline into the VGA stream.
module reel_sprite_reader #(
  parameter int          REEL_X   = 256,
  parameter int          REEL_Y   = 176,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic        spin_start,
  input  logic        stop_req,
  input  logic [3:0]  speed,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_pixel,
  output logic [23:0] pix_out,
  output logic        pix_out_valid,
  output logic        spinning,
  output logic [2:0]  result_symbol,
  output logic        result_valid
);

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING, STOPPED} state_t;

  state_t      state, state_next;
  logic [9:0]  scroll, scroll_next;
  logic [3:0]  s_eff;
  logic [7:0]  low_sum;

  assign s_eff   = (speed == 4'd0) ? 4'd1 : speed;
  // At most 127 + 15, so bit 7 alone says "crosses the next symbol boundary".
  assign low_sum = {1'b0, scroll[6:0]} + {4'b0, s_eff};

  always_comb begin
    state_next  = state;
    scroll_next = scroll;
    case (state)
      IDLE: begin
        if (spin_start) state_next = SPIN;
      end
      SPIN: begin
        if (frame_tick) scroll_next = scroll + {6'b0, s_eff};
        if (stop_req)   state_next  = STOPPING;
      end
      STOPPING: begin
        if (frame_tick) begin
          if (scroll[6:0] == 7'd0) begin
            state_next = STOPPED;
          end else if (low_sum[7]) begin
            scroll_next = {scroll[9:7] + 3'd1, 7'b0};
            state_next  = STOPPED;
          end else begin
            scroll_next = scroll + {6'b0, s_eff};
          end
        end
      end
      STOPPED: begin
        if (spin_start) state_next = SPIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      scroll        <= 10'd0;
      result_symbol <= 3'd0;
    end else begin
      state  <= state_next;
      scroll <= scroll_next;
      if (state != STOPPED && state_next == STOPPED)
        result_symbol <= scroll_next[9:7];
    end
  end

  assign spinning     = (state == SPIN) || (state == STOPPING);
  assign result_valid = (state == STOPPED);

  // Window test: a column left of the window wraps the 11-bit difference
  // to a large value, so a single "< 128" covers both bounds.
  logic [10:0] xr, yr;
  logic        in_win;
  logic [9:0]  row;

  assign xr     = {1'b0, pix_x} - 11'(REEL_X);
  assign yr     = {1'b0, pix_y} - 11'(REEL_Y);
  assign in_win = pix_valid && (xr < 11'd128) && (yr < 11'd128);
  assign row    = scroll + yr[9:0];

  logic win1, win2, vld1, vld2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr      <= 17'd0;
      win1          <= 1'b0;
      win2          <= 1'b0;
      vld1          <= 1'b0;
      vld2          <= 1'b0;
      pix_out       <= 24'd0;
      pix_out_valid <= 1'b0;
    end else begin
      if (in_win) rom_addr <= {row, xr[6:0]};
      win1          <= in_win;
      vld1          <= pix_valid;
      win2          <= win1;
      vld2          <= vld1;
      pix_out       <= vld2 ? (win2 ? rom_pixel : BG_COLOR) : 24'd0;
      pix_out_valid <= vld2;
    end
  end

endmodule
